// File: rtl/register_file_ctrl_4_if.sv
`default_nettype none
// ============================================================================
// Module   : register_file_ctrl_4_if
// Brief    : Instruction handshake, register-file port and status bundle for
//            the register_file_ctrl_4 sequencer.
// Revision : 1.0
// ============================================================================
interface register_file_ctrl_4_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic             i_instr_valid;
    logic             o_instr_ready;
    logic [1:0]       i_opcode;
    logic [1:0]       i_rd;
    logic [1:0]       i_rs0;
    logic [1:0]       i_rs1;
    logic [W-1:0]     i_imm;
    logic [1:0]       o_reg_read_0;
    logic [1:0]       o_reg_read_1;
    logic [1:0]       o_reg_write;
    logic [W-1:0]     o_port_write;
    logic             o_write_enable;
    logic [W-1:0]     i_port_read_0;
    logic [W-1:0]     i_port_read_1;
    logic             o_done;
    logic [W-1:0]     o_result;
    logic             o_carry;
    logic             o_zero;
    logic [CNT_W-1:0] o_instr_count;

    // Controller side
    modport slave (
        input  i_instr_valid, i_opcode, i_rd, i_rs0, i_rs1, i_imm,
        input  i_port_read_0, i_port_read_1,
        output o_instr_ready, o_reg_read_0, o_reg_read_1, o_reg_write,
        output o_port_write, o_write_enable, o_done, o_result, o_carry,
        output o_zero, o_instr_count
    );

    // Upstream decoder plus register file side
    modport master (
        output i_instr_valid, i_opcode, i_rd, i_rs0, i_rs1, i_imm,
        output i_port_read_0, i_port_read_1,
        input  o_instr_ready, o_reg_read_0, o_reg_read_1, o_reg_write,
        input  o_port_write, o_write_enable, o_done, o_result, o_carry,
        input  o_zero, o_instr_count
    );
endinterface
`default_nettype wire

// File: rtl/register_file_ctrl_4.sv
`default_nettype none
// ============================================================================
// Module   : register_file_ctrl_4
// Brief    : Three-cycle IDLE/EXEC/DONE sequencer that reads two registers,
//            runs a small ALU and writes the result back to a 4x4 regfile.
// Revision : 1.0
// ============================================================================
module register_file_ctrl_4 #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst,
    register_file_ctrl_4_if.slave  bus
);
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_EXEC = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    localparam logic [1:0] c_OP_LDI = 2'd0;
    localparam logic [1:0] c_OP_ADD = 2'd1;
    localparam logic [1:0] c_OP_SUB = 2'd2;
    localparam logic [1:0] c_OP_AND = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       r_opcode;
    logic [1:0]       r_rd;
    logic [1:0]       r_rs0;
    logic [1:0]       r_rs1;
    logic [W-1:0]     r_imm;
    logic [W-1:0]     r_result;
    logic             r_carry;
    logic             r_zero;
    logic [CNT_W-1:0] r_count;

    logic [W:0]       w_sum;
    logic [W-1:0]     w_diff;
    logic [W-1:0]     w_alu_res;
    logic             w_alu_carry;
    logic             w_exec;

    assign w_exec = (r_state == c_S_EXEC);
    assign w_sum  = {1'b0, bus.i_port_read_0} + {1'b0, bus.i_port_read_1};
    assign w_diff = bus.i_port_read_0 - bus.i_port_read_1;

    // LDI and AND leave the carry flag as it was
    always_comb begin
        w_alu_res   = r_imm;
        w_alu_carry = r_carry;
        case (r_opcode)
            c_OP_LDI: w_alu_res = r_imm;
            c_OP_ADD: begin
                w_alu_res   = w_sum[W-1:0];
                w_alu_carry = w_sum[W];
            end
            c_OP_SUB: begin
                w_alu_res   = w_diff;
                w_alu_carry = (bus.i_port_read_0 >= bus.i_port_read_1);
            end
            c_OP_AND: w_alu_res = bus.i_port_read_0 & bus.i_port_read_1;
            default:  w_alu_res = r_imm;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= c_S_IDLE;
            r_opcode <= '0;
            r_rd     <= '0;
            r_rs0    <= '0;
            r_rs1    <= '0;
            r_imm    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (bus.i_instr_valid) begin
                        r_opcode <= bus.i_opcode;
                        r_rd     <= bus.i_rd;
                        r_rs0    <= bus.i_rs0;
                        r_rs1    <= bus.i_rs1;
                        r_imm    <= bus.i_imm;
                        r_state  <= c_S_EXEC;
                    end
                end
                c_S_EXEC: begin
                    r_result <= w_alu_res;
                    r_carry  <= w_alu_carry;
                    r_zero   <= (w_alu_res == '0);
                    r_count  <= r_count + 1'b1;
                    r_state  <= c_S_DONE;
                end
                c_S_DONE: r_state <= c_S_IDLE;
                default:  r_state <= c_S_IDLE;
            endcase
        end
    end

    assign bus.o_instr_ready  = (r_state == c_S_IDLE);
    assign bus.o_reg_read_0   = r_rs0;
    assign bus.o_reg_read_1   = r_rs1;
    assign bus.o_reg_write    = r_rd;
    // A reset landing in EXEC must not corrupt the register file
    assign bus.o_write_enable = w_exec && !i_rst;
    assign bus.o_port_write   = w_exec ? w_alu_res : '0;
    assign bus.o_done         = (r_state == c_S_DONE) && !i_rst;
    assign bus.o_result       = r_result;
    assign bus.o_carry        = r_carry;
    assign bus.o_zero         = r_zero;
    assign bus.o_instr_count  = r_count;
endmodule
`default_nettype wire
